inc_share_arbiter: RTL
======================

// Module: inc_share_arbiter
// PURPOSE
//  Shares one WIDTH-bit ripple incrementer (halfadder chain, carry-in tied 1) among NREQ requesters.
//  Round-robin arbitration, operand capture, registered result with valid/ready backpressure.
//  Sits between requester blocks needing "+1" (counters, address stepping) and the single datapath.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  4  operand/result width in bits
//  IDW    2  width of requester index, = clog2(NREQ)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  req        in   NREQ        per-requester request; held high until its gnt bit is seen
//  req_data   in   NREQ*WIDTH  operands; requester i at [i*WIDTH +: WIDTH]
//  gnt        out  NREQ        one-hot grant, registered, one-cycle pulse
//  busy       out  1           high in EXEC and RESP
//  res_valid  out  1           result valid
//  res_data   out  WIDTH       operand + 1, modulo 2^WIDTH
//  res_carry  out  1           carry out of the MSB (operand was all ones)
//  res_id     out  IDW         index of the requester owning the result
//  res_ready  in   1           consumer accepts the result when res_valid & res_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, op_reg=0; all outputs 0.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE:
//   - req==0: stay.
//   - else: winner = first set req bit searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - Same edge: op_reg<=req_data[winner], id_reg<=winner, gnt<=onehot(winner),
//     rr_ptr<=(winner+1) mod NREQ, ->EXEC.
//  EXEC (exactly 1 cycle):
//   - gnt high this cycle only.
//   - Incrementer operates on op_reg.
//   - Edge: res_data/res_carry/res_id registered, res_valid<=1, ->RESP.
//  RESP:
//   - res_valid, res_data, res_carry, res_id held stable until res_valid & res_ready.
//   - On that edge: res_valid<=0, ->IDLE. No arbitration in this cycle.
//   - res_data/res_carry/res_id retain their last values after the handshake.
//  Latency: req seen in IDLE at edge N -> gnt high in cycle N..N+1 -> res_valid from edge N+1.
//  Throughput: minimum 3 cycles per operation, with res_ready held high.
//  Arithmetic:
//   - res_data = op_reg + 1 truncated to WIDTH.
//   - res_carry = &op_reg. Example: 4'hF -> res_data 4'h0, res_carry 1.
//  Simultaneous requests: exactly one grant per operation. Losers stay pending, never dropped.
//  Fairness: a continuously asserted req is granted within NREQ operations.
//  Deasserted req: a req dropped before its grant is not served. No state is kept per requester.
//  req_data is sampled only on the grant edge. Later changes do not affect the result.
//  Reset mid-operation (EXEC or RESP): pending result discarded, all state returns to reset values.
//   Next grant goes to the lowest-index requester.
// TESTING
//  T1 reset: rst_n=0 during activity -> gnt=0, busy=0, res_valid=0, res_data=0, res_id=0 immediately.
//  T2 single: req=4'b0001, req_data[3:0]=4'h5, res_ready=1
//     -> gnt=4'b0001 one cycle, then res_valid=1, res_data=4'h6, res_carry=0, res_id=0.
//  T3 wrap: requester 2, operand 4'hF -> res_data=4'h0, res_carry=1, res_id=2.
//  T4 round-robin: req=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0; each result = own operand+1.
//  T5 backpressure: res_ready=0 for 5 cycles in RESP
//     -> res_valid/res_data/res_id stable, no gnt while a req is pending.
//     Raise res_ready -> one-cycle accept, then IDLE, then next grant.
//  T6 reset in EXEC: rst_n pulse while rr_ptr=2 -> no res_valid; after release, req=4'b1100 -> gnt=4'b0100.

Source files
------------

// File: rtl/inc_share_arbiter_if.sv
// Requester/consumer bus for inc_share_arbiter.
//   req        requester -> arbiter  per-requester request, held until its gnt bit is seen
//   req_data   requester -> arbiter  packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        arbiter -> requester  one-hot grant, one-cycle pulse
//   busy       arbiter -> requester  operation in flight
//   res_valid  arbiter -> consumer   result valid
//   res_data   arbiter -> consumer   operand + 1 modulo 2^WIDTH
//   res_carry  arbiter -> consumer   carry out of the MSB
//   res_id     arbiter -> consumer   index of the requester owning the result
//   res_ready  consumer -> arbiter   result accepted when res_valid & res_ready
interface inc_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_data;
    logic                  res_carry;
    logic [IDW-1:0]        res_id;
    logic                  res_ready;

    // Requester and consumer side.
    modport master (
        output req, req_data, res_ready,
        input  gnt, busy, res_valid, res_data, res_carry, res_id
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, res_ready,
        output gnt, busy, res_valid, res_data, res_carry, res_id
    );
endinterface

// File: rtl/inc_share_arbiter.sv
// Shares one ripple incrementer (half-adder chain, carry-in 1) among NREQ
// requesters with round-robin arbitration and a valid/ready result port.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    inc_share_arbiter_if.slave (req/req_data in, gnt/busy/res_* out, res_ready in)
module inc_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    inc_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic [IDW-1:0]   res_id_q, res_id_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   win_next;
    logic [WIDTH-1:0] win_op;
    logic [NREQ-1:0]  win_onehot;

    logic [WIDTH-1:0] inc_sum;
    logic [WIDTH:0]   inc_carry;

    // Round-robin pick: first pass covers rr_ptr..NREQ-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_next   = '0;
        win_op     = '0;
        win_onehot = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!win_found && bus.req[i] && (i >= int'(rr_ptr_q))) begin
                win_found  = 1'b1;
                win_idx    = IDW'(i);
                win_next   = IDW'((i + 1) % int'(NREQ));
                win_op     = bus.req_data[i*WIDTH +: WIDTH];
                win_onehot = NREQ'(1) << i;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!win_found && bus.req[i]) begin
                win_found  = 1'b1;
                win_idx    = IDW'(i);
                win_next   = IDW'((i + 1) % int'(NREQ));
                win_op     = bus.req_data[i*WIDTH +: WIDTH];
                win_onehot = NREQ'(1) << i;
            end
        end
    end

    // Shared ripple incrementer: half-adder chain with carry-in tied high.
    always_comb begin
        inc_sum      = '0;
        inc_carry    = '0;
        inc_carry[0] = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            inc_sum[i]     = op_q[i] ^ inc_carry[i];
            inc_carry[i+1] = op_q[i] & inc_carry[i];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        id_d        = id_q;
        gnt_d       = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_id_d    = res_id_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_d     = win_op;
                    id_d     = win_idx;
                    gnt_d    = win_onehot;
                    rr_ptr_d = win_next;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = inc_sum;
                res_carry_d = inc_carry[WIDTH];
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Handshake cycle only; arbitration resumes from IDLE on the next edge.
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_id_q    <= res_id_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_id    = res_id_q;

endmodule
